exm_result_queue: RTL
=====================

// Module: exm_result_queue
// PURPOSE
// - EX/MEM-to-WB result buffer with operand/CSR forwarding; parametrised successor of the single-register EX->WB latch.
// - Sits between execute logic (ALU/mul/div/dcache) and WB; holds up to DEPTH completed results while WB stalls.
// - Forwards from its own queued entries and NUM_FWD external sources so EX issue continues while WB is stalled.
// PARAMETERS
// DATA_W      32   GPR/CSR data and PC width
// RADDR_W     5    GPR address width (address 0 never forwarded)
// CADDR_W     14   CSR address width
// NUM_FWD     2    external forwarding channels (index 0 = youngest)
// DEPTH       2    result queue entries (>=1; power of 2 not required)
// PORTS
// clk            in   1                 clock
// reset          in   1                 synchronous, active-high reset
// in_valid       in   1                 EX holds an instruction
// ex_done        in   1                 multi-cycle units (div, dcache) finished this cycle
// in_ready       out  1                 queue can accept (count<DEPTH)
// nblock         out  1                 !in_valid | (ex_done & in_ready)
// flush          in   1                 kill queue contents and current EX instruction
// rj_addr        in   RADDR_W           src1 GPR address
// rkd_addr       in   RADDR_W           src2 GPR address
// rj_rf          in   DATA_W            src1 regfile value
// rkd_rf         in   DATA_W            src2 regfile value
// csr_use        in   1                 instruction reads a CSR
// csr_raddr      in   CADDR_W           CSR read address
// csr_rf         in   DATA_W            CSR file read data
// rj_value       out  DATA_W            forwarded src1
// rkd_value      out  DATA_W            forwarded src2
// csr_rdata      out  DATA_W            forwarded CSR value
// fwd_valid      in   NUM_FWD           external source valid
// fwd_gr_we      in   NUM_FWD           external source writes GPR
// fwd_dest       in   NUM_FWD*RADDR_W   external GPR dest, packed, ch i at [i*RADDR_W+:RADDR_W]
// fwd_data       in   NUM_FWD*DATA_W    external GPR data, packed likewise
// fwd_csr_we     in   NUM_FWD           external source writes CSR
// fwd_csr_addr   in   NUM_FWD*CADDR_W   external CSR address, packed
// fwd_csr_data   in   NUM_FWD*DATA_W    external CSR write data, packed
// res_gr_we/res_dest/res_data/res_csr_wen/res_csr_addr/res_csr_wdata/res_pc  in  1/RADDR_W/DATA_W/1/CADDR_W/DATA_W/DATA_W  result fields
// out_valid      out  1                 queue head valid to WB
// out_ready      in   1                 WB accepts head (ws_ready)
// out_*          out  same as res_*     head entry fields
// blk_cycles     out  16                saturating count of cycles with in_valid & !nblock
// BEHAVIOUR
// - Reset: count=0, rd/wr pointers=0, out_valid=0, all out_* =0, blk_cycles=0; in_ready=1 next cycle.
// - Push = in_valid & ex_done & in_ready & !flush; payload = res_* sampled that edge; visible at head 1 cycle later.
// - Pop = out_valid & out_ready & !flush. Push and pop same cycle: count unchanged, both pointers advance.
// - in_ready = (count<DEPTH), registered state only; no combinational path from out_ready (full + pop does NOT accept).
// - Pointers wrap DEPTH-1 -> 0; count never exceeds DEPTH nor underflows (push ignored when full, pop when empty).
// - out_valid = (count!=0); out_* = entry at rd pointer; out_* hold stable while out_valid & !out_ready.
// - flush: next cycle count=0, out_valid=0, pointers=0; same-cycle push dropped; flush beats simultaneous push/pop.
// - GPR forwarding (combinational), per operand, first match wins:
//   1 queue entries newest->oldest (only valid entries with gr_we), 2 external ch 0..NUM_FWD-1, 3 regfile value.
//   Match requires dest==addr and addr!=0; addr 0 always returns rj_rf/rkd_rf.
// - CSR forwarding: same priority with csr_wen/csr_addr; applied only when csr_use, else csr_rdata=csr_rf.
// - Flushed entries never forward in cycles after the flush; in the flush cycle itself forwarding still uses current contents.
// - blk_cycles increments when in_valid & !nblock, saturates at 16'hFFFF, cleared only by reset.
// TESTING
// - Reset then idle: out_valid=0, in_ready=1, blk_cycles=0, rj_value=rj_rf for any rj_addr.
// - DEPTH=2, out_ready=0, push A(dest=3,data=0x11) then B(dest=3,data=0x22) -> in_ready=0, rj_addr=3 gives 0x22; third push stalls, nblock=0.
// - Full queue, out_ready=1 for 2 cycles -> A then B in order, in_ready rises cycle after first pop; simultaneous push+pop keeps count.
// - fwd ch0 dest=5 data=0xAA, ch1 dest=5 data=0xBB, queue empty -> rkd_value=0xAA; rkd_addr=0 with match -> rkd_rf.
// - Queue holds csr_wen entry addr=0x6 wdata=0x1234, csr_use=1 csr_raddr=0x6 -> csr_rdata=0x1234; csr_use=0 -> csr_rf.
// - flush with full queue plus same-cycle push -> next cycle out_valid=0, count=0; ex_done=0 for 70000 cycles -> blk_cycles=0xFFFF.

Source files
------------

// File: rtl/exm_result_queue_if.sv
// Write-back side of the EX/MEM result queue: head entry handshake and payload.
interface exm_result_queue_if #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int CADDR_W = 14
);
    logic               out_valid;
    logic               out_ready;
    logic               out_gr_we;
    logic [RADDR_W-1:0] out_dest;
    logic [DATA_W-1:0]  out_data;
    logic               out_csr_wen;
    logic [CADDR_W-1:0] out_csr_addr;
    logic [DATA_W-1:0]  out_csr_wdata;
    logic [DATA_W-1:0]  out_pc;

    modport master (
        output out_valid, out_gr_we, out_dest, out_data,
               out_csr_wen, out_csr_addr, out_csr_wdata, out_pc,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_gr_we, out_dest, out_data,
               out_csr_wen, out_csr_addr, out_csr_wdata, out_pc,
        output out_ready
    );
endinterface

// File: rtl/exm_result_queue.sv
// EX/MEM-to-WB result queue: buffers completed results while WB stalls and
// forwards GPR/CSR values from queued entries and external pipeline sources.
module exm_result_queue #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int CADDR_W = 14,
    parameter int NUM_FWD = 2,
    parameter int DEPTH   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic                       ex_done,
    output logic                       in_ready,
    output logic                       nblock,
    input  logic                       flush,
    input  logic [RADDR_W-1:0]         rj_addr,
    input  logic [RADDR_W-1:0]         rkd_addr,
    input  logic [DATA_W-1:0]          rj_rf,
    input  logic [DATA_W-1:0]          rkd_rf,
    input  logic                       csr_use,
    input  logic [CADDR_W-1:0]         csr_raddr,
    input  logic [DATA_W-1:0]          csr_rf,
    output logic [DATA_W-1:0]          rj_value,
    output logic [DATA_W-1:0]          rkd_value,
    output logic [DATA_W-1:0]          csr_rdata,
    input  logic [NUM_FWD-1:0]         fwd_valid,
    input  logic [NUM_FWD-1:0]         fwd_gr_we,
    input  logic [NUM_FWD*RADDR_W-1:0] fwd_dest,
    input  logic [NUM_FWD*DATA_W-1:0]  fwd_data,
    input  logic [NUM_FWD-1:0]         fwd_csr_we,
    input  logic [NUM_FWD*CADDR_W-1:0] fwd_csr_addr,
    input  logic [NUM_FWD*DATA_W-1:0]  fwd_csr_data,
    input  logic                       res_gr_we,
    input  logic [RADDR_W-1:0]         res_dest,
    input  logic [DATA_W-1:0]          res_data,
    input  logic                       res_csr_wen,
    input  logic [CADDR_W-1:0]         res_csr_addr,
    input  logic [DATA_W-1:0]          res_csr_wdata,
    input  logic [DATA_W-1:0]          res_pc,
    exm_result_queue_if.master         wb,
    output logic [15:0]                blk_cycles
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic               gr_we;
        logic [RADDR_W-1:0] dest;
        logic [DATA_W-1:0]  data;
        logic               csr_wen;
        logic [CADDR_W-1:0] csr_addr;
        logic [DATA_W-1:0]  csr_wdata;
        logic [DATA_W-1:0]  pc;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      blk_q, blk_d;
    logic             out_valid;
    logic             push;
    logic             pop;
    entry_t           head;
    entry_t           new_ent;
    entry_t           fwd_ent;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Slot holding the k-th newest entry (k=0 is the most recent push).
    function automatic logic [PTR_W-1:0] age_idx(input logic [PTR_W-1:0] wp, input int k);
        int t;
        t = (int'(wp) + DEPTH - 1 - k) % DEPTH;
        return PTR_W'(t);
    endfunction

    assign out_valid = (count_q != '0);
    assign in_ready  = (count_q < CNT_W'(DEPTH));
    assign nblock    = !in_valid | (ex_done & in_ready);
    assign push      = in_valid & ex_done & in_ready & !flush;
    assign pop       = out_valid & wb.out_ready & !flush;

    assign new_ent = '{gr_we: res_gr_we, dest: res_dest, data: res_data,
                       csr_wen: res_csr_wen, csr_addr: res_csr_addr,
                       csr_wdata: res_csr_wdata, pc: res_pc};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = new_ent;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_comb begin
        blk_d = blk_q;
        if (in_valid && !nblock && (blk_q != 16'hFFFF)) begin
            blk_d = blk_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            blk_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            blk_q    <= blk_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Lowest priority is applied first so later (higher priority) matches overwrite.
    always_comb begin
        rj_value  = rj_rf;
        rkd_value = rkd_rf;
        csr_rdata = csr_rf;
        fwd_ent   = '0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && fwd_gr_we[i]) begin
                if ((rj_addr != '0) && (fwd_dest[i*RADDR_W +: RADDR_W] == rj_addr)) begin
                    rj_value = fwd_data[i*DATA_W +: DATA_W];
                end
                if ((rkd_addr != '0) && (fwd_dest[i*RADDR_W +: RADDR_W] == rkd_addr)) begin
                    rkd_value = fwd_data[i*DATA_W +: DATA_W];
                end
            end
            if (csr_use && fwd_valid[i] && fwd_csr_we[i]
                && (fwd_csr_addr[i*CADDR_W +: CADDR_W] == csr_raddr)) begin
                csr_rdata = fwd_csr_data[i*DATA_W +: DATA_W];
            end
        end
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (k < int'(count_q)) begin
                fwd_ent = mem_q[age_idx(wr_ptr_q, k)];
                if (fwd_ent.gr_we) begin
                    if ((rj_addr != '0) && (fwd_ent.dest == rj_addr)) begin
                        rj_value = fwd_ent.data;
                    end
                    if ((rkd_addr != '0) && (fwd_ent.dest == rkd_addr)) begin
                        rkd_value = fwd_ent.data;
                    end
                end
                if (csr_use && fwd_ent.csr_wen && (fwd_ent.csr_addr == csr_raddr)) begin
                    csr_rdata = fwd_ent.csr_wdata;
                end
            end
        end
    end

    assign head              = mem_q[rd_ptr_q];
    assign wb.out_valid      = out_valid;
    assign wb.out_gr_we      = head.gr_we;
    assign wb.out_dest       = head.dest;
    assign wb.out_data       = head.data;
    assign wb.out_csr_wen    = head.csr_wen;
    assign wb.out_csr_addr   = head.csr_addr;
    assign wb.out_csr_wdata  = head.csr_wdata;
    assign wb.out_pc         = head.pc;
    assign blk_cycles        = blk_q;

endmodule
